// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI-to-register bridge: widths, command layout
// and FSM state encoding.
package spi_reg_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 7;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int CMD_READ_BIT       = 7;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    COMMAND      = 3'd1,
    WRITE        = 3'd2,
    READ_ISSUE   = 3'd3,
    READ_CAPTURE = 3'd4,
    READ_OFFER   = 3'd5
  } state_t;

endpackage

// File: rtl/spi_reg_edge.sv
// Registered edge detector: compares the current level with its value from
// the previous clock to flag rising and falling transitions.
module spi_reg_edge (
  input  logic clock,
  input  logic not_reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_reg;

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      level_reg <= 1'b0;
    end else begin
      level_reg <= level;
    end
  end

  assign rise = level & ~level_reg;
  assign fall = ~level & level_reg;

endmodule

// File: rtl/spi_reg_bridge.sv
// Turns chip-select framed SPI byte streams into register-bus reads/writes
// with address auto-increment; read data is prefetched and offered back.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  // The command byte carries a 7-bit address, so only 7 is meaningful here.
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  not_reset,
  input  logic                  active,
  input  logic                  in_data_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_data_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_data_ready,
  output logic [ADDR_WIDTH-1:0] reg_address,
  output logic                  reg_write,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic                  reg_read,
  input  logic [DATA_WIDTH-1:0] reg_read_data,
  output logic                  busy
);

  state_t state_reg, state_next;

  logic active_rise, active_fall;
  logic cmd_accept, write_accept, offer_taken;

  logic                  out_data_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [ADDR_WIDTH-1:0] reg_address_reg;
  logic                  reg_write_reg;
  logic [DATA_WIDTH-1:0] reg_write_data_reg;

  spi_reg_edge u_active_edge (
    .clock     (clock),
    .not_reset (not_reset),
    .level     (active),
    .rise      (active_rise),
    .fall      (active_fall)
  );

  // Chip-select edges override everything, so bytes coinciding with them are dropped.
  assign cmd_accept   = (state_reg == COMMAND) && in_data_valid && !active_fall && !active_rise;
  assign write_accept = (state_reg == WRITE) && in_data_valid && !active_fall && !active_rise;
  assign offer_taken  = (state_reg == READ_OFFER) && out_data_valid_reg && out_data_ready
                        && !active_fall && !active_rise;

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (active_fall) begin
      state_next = IDLE;
    end else if (active_rise) begin
      state_next = COMMAND;
    end else begin
      case (state_reg)
        IDLE:         state_next = IDLE;
        COMMAND: begin
          if (cmd_accept) begin
            state_next = in_data[CMD_READ_BIT] ? READ_ISSUE : WRITE;
          end
        end
        WRITE:        state_next = WRITE;
        READ_ISSUE:   state_next = READ_CAPTURE;
        READ_CAPTURE: state_next = READ_OFFER;
        READ_OFFER: begin
          if (offer_taken) begin
            state_next = READ_ISSUE;
          end
        end
        default:      state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    reg_read = (state_reg == READ_ISSUE);
    busy     = (state_reg != IDLE);
  end

  // Datapath: the address steps after each completed write or accepted read byte.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      out_data_valid_reg <= 1'b0;
      out_data_reg       <= '0;
      reg_address_reg    <= '0;
      reg_write_reg      <= 1'b0;
      reg_write_data_reg <= '0;
    end else begin
      reg_write_reg      <= write_accept;
      out_data_valid_reg <= (state_next == READ_OFFER);
      if (write_accept) begin
        reg_write_data_reg <= in_data;
      end
      if (state_reg == READ_CAPTURE) begin
        out_data_reg <= reg_read_data;
      end
      if (cmd_accept) begin
        reg_address_reg <= in_data[ADDR_WIDTH-1:0];
      end else if (reg_write_reg || offer_taken) begin
        reg_address_reg <= reg_address_reg + ADDR_WIDTH'(1);
      end
    end
  end

  assign out_data_valid = out_data_valid_reg;
  assign out_data       = out_data_reg;
  assign reg_address    = reg_address_reg;
  assign reg_write      = reg_write_reg;
  assign reg_write_data = reg_write_data_reg;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: table of planned transactions, random transactions
// checked against a transaction-level model, and hand-written corner cases.
module tb_spi_reg_bridge;

  logic       clock = 1'b0;
  logic       not_reset = 1'b0;
  logic       active = 1'b0;
  logic       in_data_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_data_valid;
  logic [7:0] out_data;
  logic       out_data_ready = 1'b0;
  logic [6:0] reg_address;
  logic       reg_write;
  logic [7:0] reg_write_data;
  logic       reg_read;
  logic [7:0] reg_read_data = 8'h00;
  logic       busy;

  always #5 clock = ~clock;

  spi_reg_bridge dut (
    .clock          (clock),
    .not_reset      (not_reset),
    .active         (active),
    .in_data_valid  (in_data_valid),
    .in_data        (in_data),
    .out_data_valid (out_data_valid),
    .out_data       (out_data),
    .out_data_ready (out_data_ready),
    .reg_address    (reg_address),
    .reg_write      (reg_write),
    .reg_write_data (reg_write_data),
    .reg_read       (reg_read),
    .reg_read_data  (reg_read_data),
    .busy           (busy)
  );

  int n_vec = 0;
  int n_miss = 0;
  int viol = 0;

  logic [7:0]  mem [128];
  logic [14:0] wr_q [$];
  logic [6:0]  rd_q [$];
  logic [7:0]  od_q [$];
  logic        prev_w = 1'b0;
  logic        prev_r = 1'b0;
  logic        rd_pend = 1'b0;
  logic [6:0]  rd_addr = 7'h00;

  // Bus monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (reg_write) wr_q.push_back({reg_address, reg_write_data});
    if (reg_read) rd_q.push_back(reg_address);
    if (out_data_valid && out_data_ready) od_q.push_back(out_data);
    if ((reg_write && reg_read) || (reg_write && prev_w) || (reg_read && prev_r)) viol++;
    prev_w  = reg_write;
    prev_r  = reg_read;
    rd_pend = reg_read;
    rd_addr = reg_address;
  end

  // Register file responder: data valid only in the cycle after reg_read.
  always @(posedge clock) begin
    #1;
    if (rd_pend) reg_read_data = mem[rd_addr];
    else reg_read_data = 8'($urandom);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] cmd;
    int         n;
    logic [7:0] v [3];
    logic [6:0] a [3];
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data = b;
    in_data_valid = 1'b1;
    tick();
    in_data_valid = 1'b0;
  endtask

  task automatic clear_q();
    wr_q.delete();
    rd_q.delete();
    od_q.delete();
  endtask

  task automatic start_txn();
    active = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_txn();
    active = 1'b0;
    tick();
    tick();
    chk("idle_busy", busy, 0);
  endtask

  task automatic do_write(input logic [7:0] cmd, input int nb,
                          input logic [7:0] bytes [8], input logic [6:0] ea [8]);
    logic [14:0] e;
    clear_q();
    start_txn();
    send_byte(cmd);
    repeat (1 + $urandom_range(0, 3)) tick();
    for (int i = 0; i < nb; i++) begin
      send_byte(bytes[i]);
      repeat (1 + $urandom_range(0, 3)) tick();
    end
    repeat (3) tick();
    end_txn();
    chk("wr_count", wr_q.size(), nb);
    for (int i = 0; i < nb && i < wr_q.size(); i++) begin
      e = wr_q[i];
      chk("wr_addr", e[14:8], ea[i]);
      chk("wr_data", e[7:0], bytes[i]);
    end
    chk("wr_no_read", rd_q.size(), 0);
    $display("write cmd=%02h bytes=%0d writes_seen=%0d", cmd, nb, wr_q.size());
  endtask

  task automatic do_read(input logic [7:0] cmd, input int n,
                         input logic [6:0] ea [8], input logic [7:0] ed [8]);
    int k;
    clear_q();
    start_txn();
    send_byte(cmd);
    tick();
    chk("lat_1clk_valid", out_data_valid, 0);
    tick();
    chk("lat_2clk_valid", out_data_valid, 1);
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!out_data_valid && k < 20) begin
        tick();
        k++;
      end
      chk("offer_valid", out_data_valid, 1);
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
      out_data_ready = 1'b1;
      tick();
      out_data_ready = 1'b0;
    end
    repeat (4) tick();
    end_txn();
    chk("rd_out_count", od_q.size(), n);
    for (int i = 0; i < n && i < od_q.size(); i++) chk("rd_out_data", od_q[i], ed[i]);
    chk("rd_issue_count", rd_q.size(), n + 1);
    for (int i = 0; i <= n && i < rd_q.size(); i++) chk("rd_addr", rd_q[i], ea[i]);
    chk("rd_no_write", wr_q.size(), 0);
    $display("read  cmd=%02h beats=%0d reads_seen=%0d outs_seen=%0d", cmd, n, rd_q.size(), od_q.size());
  endtask

  initial begin
    logic [7:0] bytes [8];
    logic [6:0] ea [8];
    logic [7:0] ed [8];
    logic [7:0] cmd;
    logic [14:0] e;
    int n;

    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[7'h05] = 8'h5A;
    mem[7'h06] = 8'h5B;
    mem[7'h7F] = 8'hC3;
    mem[7'h00] = 8'h3C;

    tbl[0] = '{cmd: 8'h10, n: 2, v: '{8'hAA, 8'hBB, 8'h00}, a: '{7'h10, 7'h11, 7'h12}};
    tbl[1] = '{cmd: 8'h7F, n: 2, v: '{8'h01, 8'h02, 8'h00}, a: '{7'h7F, 7'h00, 7'h01}};
    tbl[2] = '{cmd: 8'h85, n: 2, v: '{8'h5A, 8'h5B, 8'h00}, a: '{7'h05, 7'h06, 7'h07}};
    tbl[3] = '{cmd: 8'hFF, n: 2, v: '{8'hC3, 8'h3C, 8'h00}, a: '{7'h7F, 7'h00, 7'h01}};

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_reg_read", reg_read, 0);
    chk("rst_out_valid", out_data_valid, 0);
    chk("rst_reg_address", reg_address, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_write_data", reg_write_data, 0);
    not_reset = 1'b1;
    tick();

    // Planned transactions
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 8; i++) begin
        bytes[i] = 8'h00;
        ea[i] = 7'h00;
        ed[i] = 8'h00;
      end
      for (int i = 0; i < 3; i++) begin
        bytes[i] = tbl[t].v[i];
        ed[i] = tbl[t].v[i];
        ea[i] = tbl[t].a[i];
      end
      if (tbl[t].cmd[7]) do_read(tbl[t].cmd, tbl[t].n, ea, ed);
      else do_write(tbl[t].cmd, tbl[t].n, bytes, ea);
    end

    // Random transactions against the transaction-level model
    for (int t = 0; t < 16; t++) begin
      cmd = 8'($urandom);
      n = $urandom_range(1, 5);
      for (int i = 0; i < 8; i++) begin
        ea[i] = 7'((cmd & 8'h7F) + i);
        bytes[i] = 8'($urandom);
        ed[i] = mem[ea[i]];
      end
      if (cmd[7]) do_read(cmd, n, ea, ed);
      else do_write(cmd, n, bytes, ea);
    end

    // Abort while a read byte is on offer
    clear_q();
    start_txn();
    send_byte(8'h85);
    tick();
    tick();
    chk("abort_pre_valid", out_data_valid, 1);
    chk("abort_pre_data", out_data, 8'h5A);
    active = 1'b0;
    tick();
    chk("abort_valid", out_data_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (5) tick();
    chk("abort_reads", rd_q.size(), 1);
    chk("abort_outs", od_q.size(), 0);
    $display("abort cmd=85 reads_seen=%0d", rd_q.size());

    // Asynchronous reset in the middle of a write burst
    clear_q();
    start_txn();
    send_byte(8'h20);
    tick();
    chk("arst_pre_addr", reg_address, 7'h20);
    chk("arst_pre_busy", busy, 1);
    #2;
    not_reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_reg_address", reg_address, 0);
    chk("arst_reg_write", reg_write, 0);
    chk("arst_reg_read", reg_read, 0);
    chk("arst_out_valid", out_data_valid, 0);
    active = 1'b0;
    tick();
    tick();
    not_reset = 1'b1;
    tick();
    $display("async reset during write cmd=20");
    for (int i = 0; i < 8; i++) begin
      bytes[i] = 8'h00;
      ea[i] = 7'h00;
    end
    bytes[0] = 8'h44;
    ea[0] = 7'h30;
    do_write(8'h30, 1, bytes, ea);

    // Byte arriving in the same cycle as chip-select release
    clear_q();
    start_txn();
    send_byte(8'h40);
    tick();
    send_byte(8'h01);
    tick();
    tick();
    in_data = 8'h02;
    in_data_valid = 1'b1;
    active = 1'b0;
    tick();
    in_data_valid = 1'b0;
    repeat (3) tick();
    chk("coll_writes", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      e = wr_q[0];
      chk("coll_first_addr", e[14:8], 7'h40);
      chk("coll_first_data", e[7:0], 8'h01);
    end
    chk("coll_busy", busy, 0);
    $display("collision cmd=40 writes_seen=%0d", wr_q.size());

    chk("strobe_rules", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
